// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order word requests to imem, buffers responses in a
// small FIFO and presents {pc, instr} to decode, holding it across stalls.
// A redirect flushes the buffer and discards responses still in flight.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                       cpu_clk_aon,
    input  logic                       i_rst,
    instruction_fetch_if.master        imem,
    input  logic                       update_pc,
    input  logic [31:0]                new_pc,
    input  logic                       cpu_stall_final,
    output logic [63:0]                instruction_reg
);

    localparam int unsigned     CW           = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned     PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_SLOT    = PW'(FIFO_DEPTH - 1);
    localparam logic [63:0]     NOP_WORD     = {32'd0, NOP_INSTR};

    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   resp_pc;
    logic [31:0]   resp_pc_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [63:0]   instr_nxt;
    logic [63:0]   resp_entry;
    logic [63:0]   head;
    logic [31:0]   target_pc;
    logic          redirect;
    logic          credit_ok;
    logic          issue;
    logic          resp_drop;
    logic          resp_acc;
    logic          push;
    logic          pop;
    logic          flush;
    logic          unused_low_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    // Request side: credit check uses registered state only, so no path from rvalid/rdata to req.
    always_comb begin
        unused_low_bits = ^new_pc[1:0];
        target_pc       = {new_pc[31:2], 2'b00};
        redirect        = update_pc & ~cpu_stall_final;
        credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < CREDIT_LIMIT;
        imem.imem_req   = ~i_rst & ~redirect & credit_ok;
        imem.imem_addr  = fetch_pc;
        issue           = imem.imem_req & imem.imem_ack;
        resp_drop       = imem.imem_rvalid & (drop_cnt != '0);
        resp_acc        = imem.imem_rvalid & (drop_cnt == '0);
        resp_entry      = {resp_pc, imem.imem_rdata};
        head            = fifo_mem[rd_ptr];
    end

    // Program-counter, in-flight and drop bookkeeping.
    always_comb begin
        fetch_pc_nxt    = fetch_pc;
        resp_pc_nxt     = resp_pc;
        drop_cnt_nxt    = drop_cnt;
        outstanding_nxt = outstanding + CW'(issue) - CW'(imem.imem_rvalid);
        if (redirect) begin
            // Everything still unanswered after this cycle becomes stale.
            fetch_pc_nxt = target_pc;
            resp_pc_nxt  = target_pc;
            drop_cnt_nxt = outstanding - CW'(imem.imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
            if (resp_acc) begin
                resp_pc_nxt = resp_pc + 32'd4;
            end
            if (resp_drop) begin
                drop_cnt_nxt = drop_cnt - CW'(1);
            end
        end
    end

    // Output selection and FIFO push/pop/flush decisions.
    always_comb begin
        instr_nxt = instruction_reg;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        if (cpu_stall_final) begin
            push = resp_acc;
        end else if (redirect) begin
            flush     = 1'b1;
            instr_nxt = NOP_WORD;
        end else if (count != '0) begin
            pop       = 1'b1;
            push      = resp_acc;
            instr_nxt = head;
        end else if (resp_acc) begin
            instr_nxt = resp_entry;
        end else begin
            instr_nxt = NOP_WORD;
        end
    end

    // FIFO occupancy and pointer updates.
    always_comb begin
        if (flush) begin
            count_nxt  = '0;
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
        end else begin
            count_nxt  = count + CW'(push) - CW'(pop);
            rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
            wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge cpu_clk_aon or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc        <= RESET_PC;
            resp_pc         <= RESET_PC;
            count           <= '0;
            outstanding     <= '0;
            drop_cnt        <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            instruction_reg <= NOP_WORD;
        end else begin
            fetch_pc        <= fetch_pc_nxt;
            resp_pc         <= resp_pc_nxt;
            count           <= count_nxt;
            outstanding     <= outstanding_nxt;
            drop_cnt        <= drop_cnt_nxt;
            rd_ptr          <= rd_ptr_nxt;
            wr_ptr          <= wr_ptr_nxt;
            instruction_reg <= instr_nxt;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge cpu_clk_aon) begin
        if (push) begin
            fifo_mem[wr_ptr] <= resp_entry;
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding the decode/execute stage. Issues in-order word requests to instruction memory and buffers returned instructions in a small FIFO. Presents `{pc, instr}` on a 64-bit `instruction_reg` and holds it while the core stalls. On a taken redirect (`update_pc`/`new_pc`), it flushes the buffer and discards in-flight responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests (legal 2..8)
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- cpu_clk_aon  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request valid
- imem_addr  out  32  word address, bits [1:0] always 0
- imem_ack  in  1  request accepted this cycle (imem_req & imem_ack = issue)
- imem_rvalid  in  1  response valid; responses return in issue order, ≥1 cycle after issue
- imem_rdata  in  32  response instruction
- update_pc  in  1  redirect request from decode
- new_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- cpu_stall_final  in  1  decode stall; hold `instruction_reg`
- instruction_reg  out  64  {pc[31:0], instr[31:0]} to decode

## Operation
State:
- fetch_pc: next issue address
- resp_pc: pc of the next accepted response
- fifo: FIFO_DEPTH entries of 64 bits, with count
- outstanding: issued requests not yet responded to
- drop_cnt: stale responses still to discard

Rules:
- redirect = update_pc & ~cpu_stall_final. A redirect asserted while stalled is ignored; decode re-asserts it.
- imem_req = ~i_rst & ~redirect & (count + outstanding < FIFO_DEPTH). This check is conservative: a same-cycle pop does not add credit.
- imem_addr = fetch_pc. On issue: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC → 0) and outstanding += 1.
- outstanding is decremented on every imem_rvalid, including dropped responses.
- Dropped response: when imem_rvalid arrives with drop_cnt > 0, discard it, decrement drop_cnt, and leave resp_pc unchanged.
- Accepted response: when imem_rvalid arrives with drop_cnt = 0, form entry {resp_pc, imem_rdata} and set resp_pc += 4.
- Output update when ~cpu_stall_final, in priority order:
  1. redirect → instruction_reg = {32'd0, NOP_INSTR}
  2. fifo nonempty → pop head into instruction_reg; an accepted response this cycle is pushed
  3. fifo empty and accepted response this cycle → bypass the entry directly into instruction_reg
  4. otherwise → {32'd0, NOP_INSTR}
- Output hold when cpu_stall_final = 1: instruction_reg holds. An accepted response is pushed into the fifo; space is guaranteed by the credit rule.
- Redirect effects at the clock edge:
  - fetch_pc ← {new_pc[31:2], 2'b00}
  - resp_pc ← the same value
  - fifo flushed
  - drop_cnt ← outstanding − (imem_rvalid & drop_cnt == 0 ? 1 : 0) + (imem_rvalid & drop_cnt > 0 ? −1 : 0), i.e. all requests still unanswered after this cycle
  - no issue in the redirect cycle
- Simultaneous events:
  - Issue and response in the same cycle: outstanding is unchanged.
  - Response and redirect in the same cycle: the response is discarded.
- Reset (asynchronous, also mid-operation):
  - fetch_pc = resp_pc = RESET_PC
  - count = outstanding = drop_cnt = 0
  - instruction_reg = {32'd0, NOP_INSTR}
- Instruction memory must be reset by the same i_rst. Responses to pre-reset requests are illegal.

## Timing
- Reset values: imem_req 0 while i_rst is high; imem_addr = RESET_PC; instruction_reg = {32'd0, 32'h0000_0013}.
- Cycle after reset deassert: imem_req = 1, imem_addr = RESET_PC.
- Best-case latency is 1 cycle after response: a response in cycle N is visible on instruction_reg in cycle N+1 via bypass.
- Redirect at edge E:
  - the first request to new_pc is issued no earlier than cycle E+1
  - instruction_reg shows a bubble from E until the new target's response is consumed
- Sustained throughput is 1 instruction/cycle when memory acks every cycle with 1-cycle response latency and FIFO_DEPTH ≥ 2.
- No combinational path from imem_rvalid/imem_rdata to imem_req. imem_req depends only on registered state, update_pc and cpu_stall_final.

## Test plan
- Reset release, memory always acks with 1-cycle latency, instrs = addr+0x100 → instruction_reg = {0x0,0x100}, {0x4,0x104}, {0x8,0x108} on consecutive cycles after the first fill.
- cpu_stall_final high for 3 cycles mid-stream → instruction_reg frozen; buffered entries are then output in order with no loss or duplicate; imem_req deasserts once count + outstanding = 2.
- update_pc = 1, new_pc = 0x0000_0203 with 2 outstanding → imem_addr = 0x200 next cycle; both stale responses dropped; first non-bubble output is {0x200, mem[0x200]}.
- update_pc = 1 while cpu_stall_final = 1 → no flush, fetch_pc unchanged, instruction_reg held.
- RESET_PC = 0xFFFF_FFF8, sequential fetch → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- i_rst pulsed mid-burst with 2 outstanding → all outputs return to reset values asynchronously; fetch restarts at RESET_PC with clean pc tags.
